// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-back, write-allocate byte cache in front of a
// 32-bit-word data memory. Hits resolve combinationally in IDLE; misses
// walk WRITEBACK (dirty victim only) -> FETCH -> UPDATE, and the original
// request then re-evaluates as a hit back in IDLE.
module dcache_ctrl #(
    parameter int NUM_BLOCKS  = 8,
    parameter int BLOCK_BYTES = 4
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic        READ,
    input  logic        WRITE,
    input  logic [7:0]  ADDRESS,
    input  logic [7:0]  WRITEDATA,
    output logic [7:0]  READDATA,
    output logic        BUSYWAIT,
    output logic        MEM_READ,
    output logic        MEM_WRITE,
    output logic [5:0]  MEM_ADDRESS,
    output logic [31:0] MEM_WRITEDATA,
    input  logic [31:0] MEM_READDATA,
    input  logic        MEM_BUSYWAIT
);
    localparam int IDX_W  = $clog2(NUM_BLOCKS);
    localparam int OFF_W  = $clog2(BLOCK_BYTES);
    localparam int TAG_W  = 8 - IDX_W - OFF_W;
    localparam int LINE_W = BLOCK_BYTES * 8;

    typedef enum logic [1:0] {S_IDLE, S_WB, S_FETCH, S_UPDATE} state_t;

    state_t                  r_state;
    logic [NUM_BLOCKS-1:0]   r_valid;
    logic [NUM_BLOCKS-1:0]   r_dirty;
    logic [TAG_W-1:0]        r_tag  [NUM_BLOCKS];
    logic [LINE_W-1:0]       r_data [NUM_BLOCKS];
    logic [LINE_W-1:0]       r_fill;
    logic [7:0]              r_readdata;
    logic                    r_mem_read;
    logic                    r_mem_write;
    logic [5:0]              r_mem_addr;
    logic [31:0]             r_mem_wdata;

    logic [TAG_W-1:0]  w_tag;
    logic [IDX_W-1:0]  w_idx;
    logic [OFF_W-1:0]  w_off;
    logic [LINE_W-1:0] w_line;
    logic [7:0]        w_byte;
    logic              w_hit, w_req, w_rd, w_wr, w_idle, w_rd_hit, w_wr_hit;

    assign w_tag    = ADDRESS[7 -: TAG_W];
    assign w_idx    = ADDRESS[OFF_W +: IDX_W];
    assign w_off    = ADDRESS[OFF_W-1:0];
    assign w_line   = r_data[w_idx];
    assign w_byte   = w_line[{w_off, 3'b000} +: 8];
    assign w_hit    = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    // READ together with WRITE is illegal; resolve it as a write.
    assign w_wr     = WRITE;
    assign w_rd     = READ & ~WRITE;
    assign w_req    = READ | WRITE;
    assign w_idle   = (r_state == S_IDLE);
    assign w_rd_hit = w_idle & w_rd & w_hit;
    assign w_wr_hit = w_idle & w_wr & w_hit;

    // Stall is combinational so a hit costs zero cycles; reset forces it low.
    assign BUSYWAIT      = RESETN & (w_idle ? (w_req & ~w_hit) : 1'b1);
    assign READDATA      = w_rd_hit ? w_byte : r_readdata;
    assign MEM_READ      = r_mem_read;
    assign MEM_WRITE     = r_mem_write;
    assign MEM_ADDRESS   = r_mem_addr;
    assign MEM_WRITEDATA = r_mem_wdata;

    // Miss FSM, line status bits and registered memory-side outputs.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            r_state     <= S_IDLE;
            r_valid     <= '0;
            r_dirty     <= '0;
            r_fill      <= '0;
            r_readdata  <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_rd_hit) r_readdata <= w_byte;
                    if (w_wr_hit) r_dirty[w_idx] <= 1'b1;
                    if (w_req && !w_hit) begin
                        if (r_valid[w_idx] && r_dirty[w_idx]) begin
                            r_state     <= S_WB;
                            r_mem_write <= 1'b1;
                            r_mem_addr  <= {r_tag[w_idx], w_idx};
                            r_mem_wdata <= w_line;
                        end else begin
                            r_state    <= S_FETCH;
                            r_mem_read <= 1'b1;
                            r_mem_addr <= {w_tag, w_idx};
                        end
                    end
                end
                S_WB: begin
                    if (!MEM_BUSYWAIT) begin
                        r_state     <= S_FETCH;
                        r_mem_write <= 1'b0;
                        r_mem_read  <= 1'b1;
                        r_mem_addr  <= {w_tag, w_idx};
                    end
                end
                S_FETCH: begin
                    // Capture the block on the completing edge; memory need
                    // not hold it into UPDATE.
                    if (!MEM_BUSYWAIT) begin
                        r_state    <= S_UPDATE;
                        r_mem_read <= 1'b0;
                        r_fill     <= MEM_READDATA;
                    end
                end
                S_UPDATE: begin
                    r_valid[w_idx] <= 1'b1;
                    r_dirty[w_idx] <= 1'b0;
                    r_state        <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Tag and data arrays: refill in UPDATE, byte merge on a write hit.
    always_ff @(posedge CLK) begin
        if (r_state == S_UPDATE) begin
            r_data[w_idx] <= r_fill;
            r_tag[w_idx]  <= w_tag;
        end else if (w_wr_hit) begin
            r_data[w_idx][{w_off, 3'b000} +: 8] <= WRITEDATA;
        end
    end
endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: behavioural word memory with fixed latency, a
// byte-level reference image for expected read data (scoreboard queue),
// and a monitor logging memory request addresses/writeback data.
module tb_dcache_ctrl;
    localparam int LAT = 2;

    logic        CLK, RESETN, READ, WRITE, BUSYWAIT, MEM_READ, MEM_WRITE, MEM_BUSYWAIT;
    logic [7:0]  ADDRESS, WRITEDATA, READDATA;
    logic [5:0]  MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA, MEM_READDATA;

    dcache_ctrl dut (
        .CLK(CLK), .RESETN(RESETN), .READ(READ), .WRITE(WRITE),
        .ADDRESS(ADDRESS), .WRITEDATA(WRITEDATA), .READDATA(READDATA),
        .BUSYWAIT(BUSYWAIT), .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE),
        .MEM_ADDRESS(MEM_ADDRESS), .MEM_WRITEDATA(MEM_WRITEDATA),
        .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] tb_mem [64];
    logic [7:0]  ref_mem [256];
    logic [7:0]  exp_q [$];
    logic [5:0]  rd_q [$];
    logic [37:0] wb_q [$];
    logic [7:0]  last_rd;
    int          cnt;
    logic        prev_rd, prev_wr;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Memory model: busy for LAT cycles of each request, completes on the
    // first edge where busy is low.
    assign MEM_BUSYWAIT = (MEM_READ | MEM_WRITE) && (cnt != LAT);
    assign MEM_READDATA = tb_mem[MEM_ADDRESS];
    always @(posedge CLK) begin
        if (!RESETN) cnt <= 0;
        else if (MEM_READ | MEM_WRITE) begin
            if (cnt == LAT) begin
                cnt <= 0;
                if (MEM_WRITE) tb_mem[MEM_ADDRESS] <= MEM_WRITEDATA;
            end else cnt <= cnt + 1;
        end else cnt <= 0;
    end

    // Monitor: log each new memory request, flag overlapping requests.
    always @(negedge CLK) begin
        if (MEM_READ && !prev_rd) rd_q.push_back(MEM_ADDRESS);
        if (MEM_WRITE && !prev_wr) wb_q.push_back({MEM_ADDRESS, MEM_WRITEDATA});
        if (MEM_READ && MEM_WRITE) begin
            n_tests++; n_fail++;
            $display("FAIL mem_excl: MEM_READ=%0b MEM_WRITE=%0b, required not both", MEM_READ, MEM_WRITE);
        end
        prev_rd <= MEM_READ;
        prev_wr <= MEM_WRITE;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "timeout");
    end

    // Drive one CPU access starting just after a rising edge; waits for the
    // stall to clear, pops the expected byte for reads and compares it.
    task automatic do_access(input logic rd, input logic wr, input logic [7:0] a,
                             input logic [7:0] d, output int stall);
        if (wr) ref_mem[a] = d;
        else exp_q.push_back(ref_mem[a]);
        READ = rd; WRITE = wr; ADDRESS = a; WRITEDATA = d;
        stall = 0;
        forever begin
            @(negedge CLK);
            if (!BUSYWAIT) break;
            stall++;
            if (stall > 40) break;
        end
        if (stall > 40) begin
            n_tests++; n_fail++;
            $display("FAIL busy_timeout: addr=%h still stalled", a);
        end else if (!wr) begin
            logic [7:0] e;
            e = exp_q.pop_front();
            last_rd = e;
            n_tests++;
            if (READDATA !== e) begin
                n_fail++;
                $display("FAIL readdata[%h]: got %h, required %h", a, READDATA, e);
            end
        end
        @(posedge CLK); #1;
        READ = 0; WRITE = 0;
    endtask

    task automatic test_reset();
        RESETN = 0; READ = 0; WRITE = 0; ADDRESS = 0; WRITEDATA = 0;
        repeat (2) @(posedge CLK);
        #2;
        n_tests++;
        if ({BUSYWAIT, MEM_READ, MEM_WRITE} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctrl: got %b, required 000", {BUSYWAIT, MEM_READ, MEM_WRITE});
        end
        n_tests++;
        if (MEM_ADDRESS !== 6'd0 || MEM_WRITEDATA !== 32'd0 || READDATA !== 8'd0) begin
            n_fail++; $display("FAIL reset_data: got %h/%h/%h, required 0", MEM_ADDRESS, MEM_WRITEDATA, READDATA);
        end
        @(negedge CLK); RESETN = 1;
        @(posedge CLK); #1;
    endtask

    task automatic test_read_miss();
        int s;
        do_access(1, 0, 8'h14, 8'h00, s);
        n_tests++;
        if (s !== LAT + 3) begin n_fail++; $display("FAIL clean_miss_stall: got %0d, required %0d", s, LAT + 3); end
        n_tests++;
        if (rd_q.size() != 1 || rd_q[0] !== 6'h05) begin
            n_fail++; $display("FAIL fetch_addr: got %0d reqs, first %h, required 1 at 05", rd_q.size(), rd_q.size() ? rd_q[0] : 6'h3f);
        end
        n_tests++;
        if (wb_q.size() != 0) begin n_fail++; $display("FAIL no_wb: got %0d writebacks, required 0", wb_q.size()); end
        rd_q.delete(); wb_q.delete();
    endtask

    task automatic test_read_hit();
        int s;
        do_access(1, 0, 8'h17, 8'h00, s);
        n_tests++;
        if (s !== 0 || rd_q.size() != 0) begin
            n_fail++; $display("FAIL read_hit: stall %0d fetches %0d, required 0/0", s, rd_q.size());
        end
    endtask

    task automatic test_write_hit();
        int s1, s2;
        do_access(0, 1, 8'h15, 8'h5A, s1);
        do_access(1, 0, 8'h15, 8'h00, s2);
        n_tests++;
        if (s1 !== 0 || s2 !== 0 || rd_q.size() != 0) begin
            n_fail++; $display("FAIL write_hit: stalls %0d/%0d fetches %0d, required 0/0/0", s1, s2, rd_q.size());
        end
    endtask

    task automatic test_dirty_miss();
        int s;
        do_access(1, 0, 8'h34, 8'h00, s);
        n_tests++;
        if (s !== 2 * LAT + 4) begin n_fail++; $display("FAIL dirty_miss_stall: got %0d, required %0d", s, 2 * LAT + 4); end
        n_tests++;
        if (wb_q.size() != 1 || wb_q[0] !== {6'h05, 32'hDDCC5AAA}) begin
            n_fail++; $display("FAIL writeback: got %0d reqs, first %h, required 1 of %h", wb_q.size(), wb_q.size() ? wb_q[0] : 38'h0, {6'h05, 32'hDDCC5AAA});
        end
        n_tests++;
        if (rd_q.size() != 1 || rd_q[0] !== 6'h0D) begin
            n_fail++; $display("FAIL refetch_addr: got %0d reqs, first %h, required 1 at 0d", rd_q.size(), rd_q.size() ? rd_q[0] : 6'h3f);
        end
        n_tests++;
        if (tb_mem[5] !== 32'hDDCC5AAA) begin n_fail++; $display("FAIL mem_word5: got %h, required ddcc5aaa", tb_mem[5]); end
        rd_q.delete(); wb_q.delete();
    endtask

    task automatic test_write_miss();
        int s;
        do_access(0, 1, 8'h02, 8'h77, s);
        n_tests++;
        if (s !== LAT + 3 || rd_q.size() != 1 || rd_q[0] !== 6'h00) begin
            n_fail++; $display("FAIL write_miss: stall %0d fetches %0d, required %0d and one at 00", s, rd_q.size(), LAT + 3);
        end
        rd_q.delete();
        do_access(1, 0, 8'h02, 8'h00, s);
        // Evicting index 0 must write back the merged byte, proving dirty=1.
        do_access(1, 0, 8'h22, 8'h00, s);
        n_tests++;
        if (s !== 2 * LAT + 4 || wb_q.size() != 1 || wb_q[0] !== {6'h00, 32'h11773344}) begin
            n_fail++; $display("FAIL write_miss_evict: stall %0d wbs %0d first %h, required %0d, 1, %h",
                               s, wb_q.size(), wb_q.size() ? wb_q[0] : 38'h0, 2 * LAT + 4, {6'h00, 32'h11773344});
        end
        rd_q.delete(); wb_q.delete();
    endtask

    task automatic test_rd_wr_both();
        int s;
        do_access(1, 1, 8'h05, 8'h3C, s);
        n_tests++;
        if (s !== LAT + 3 || rd_q.size() != 1 || rd_q[0] !== 6'h01) begin
            n_fail++; $display("FAIL both_req: stall %0d fetches %0d, required %0d and one at 01", s, rd_q.size(), LAT + 3);
        end
        rd_q.delete();
        do_access(1, 0, 8'h05, 8'h00, s);
    endtask

    task automatic test_readdata_hold();
        ADDRESS = 8'h17;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        n_tests++;
        if (READDATA !== last_rd) begin n_fail++; $display("FAIL readdata_hold: got %h, required %h", READDATA, last_rd); end
        @(posedge CLK); #1;
    endtask

    task automatic test_reset_mid_miss();
        int k, s;
        READ = 1; WRITE = 0; ADDRESS = 8'h54;
        k = 0;
        do begin @(negedge CLK); k++; end while (!(MEM_READ && MEM_BUSYWAIT) && k < 20);
        n_tests++;
        if (k >= 20) begin n_fail++; $display("FAIL mid_miss_fetch: no busy fetch within %0d cycles", k); end
        #1 RESETN = 0;
        #1;
        n_tests++;
        if ({MEM_READ, MEM_WRITE, BUSYWAIT} !== 3'b000) begin
            n_fail++; $display("FAIL reset_abort: got %b, required 000", {MEM_READ, MEM_WRITE, BUSYWAIT});
        end
        READ = 0;
        rd_q.delete(); wb_q.delete();
        @(negedge CLK); RESETN = 1;
        @(posedge CLK); #1;
        do_access(1, 0, 8'h14, 8'h00, s);
        n_tests++;
        if (s !== LAT + 3 || rd_q.size() != 1 || rd_q[0] !== 6'h05) begin
            n_fail++; $display("FAIL post_reset_miss: stall %0d fetches %0d, required %0d and one at 05", s, rd_q.size(), LAT + 3);
        end
        rd_q.delete();
    endtask

    initial begin
        for (int w = 0; w < 64; w++) tb_mem[w] = 32'hA5000000 ^ (w * 32'h01030507);
        tb_mem[0]  = 32'h11223344;
        tb_mem[1]  = 32'h87654321;
        tb_mem[5]  = 32'hDDCCBBAA;
        tb_mem[8]  = 32'h99887766;
        tb_mem[13] = 32'h44332211;
        for (int b = 0; b < 256; b++) ref_mem[b] = tb_mem[b >> 2][(b % 4) * 8 +: 8];
        last_rd = 8'h00;
        test_reset();
        test_read_miss();
        test_read_hit();
        test_write_hit();
        test_dirty_miss();
        test_write_miss();
        test_rd_wr_both();
        test_readdata_hold();
        test_reset_mid_miss();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
